pi_assist_controller: RTL

Parametrised successor to the combinational assistance calculator. Runs a sampled PI loop on heart-rate error plus uphill pitch feed-forward, gated by cadence activity, brake and a latched tilt fault. Output is slew-limited upward and killed immediately on any safety event. Sits between the IMU/biometric front-ends and the motor current-control module.

---
 rtl/pi_assist_controller_if.sv | 30 +++
 rtl/pi_assist_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pi_assist_controller_if.sv
// Signal bundle between the IMU/biometric front-ends, the assistance controller
// and the motor current-control stage.
interface pi_assist_controller_if #(
  parameter int HR_W  = 8,
  parameter int ANG_W = 10,
  parameter int OUT_W = 13
);
  logic signed [ANG_W-1:0] resolved_roll;
  logic signed [ANG_W-1:0] resolved_pitch;
  logic        [HR_W-1:0]  heart_rate;
  logic        [HR_W-1:0]  heart_rate_set_point;
  logic                    cadence;
  logic                    brake;
  logic        [OUT_W-1:0] assistance_requirement;
  logic        [1:0]       assist_state;
  logic                    fault;
  logic                    update_strobe;

  modport master (
    output resolved_roll, resolved_pitch, heart_rate, heart_rate_set_point,
    output cadence, brake,
    input  assistance_requirement, assist_state, fault, update_strobe
  );

  modport slave (
    input  resolved_roll, resolved_pitch, heart_rate, heart_rate_set_point,
    input  cadence, brake,
    output assistance_requirement, assist_state, fault, update_strobe
  );
endinterface

// File: rtl/pi_assist_controller.sv
// Sampled PI heart-rate assistance loop with pitch feed-forward, upward slew
// limit and per-clock brake/tilt safety cut-off.
//
// state    | meaning
// IDLE     | output 0, integrator cleared, waiting for pedalling
// ASSIST   | PI + ramp running; brake forces output 0 and freezes integrator
// FAULT    | tilt latched, output 0, waiting for roll to settle below re-arm level
module pi_assist_controller #(
  parameter int HR_W        = 8,
  parameter int ANG_W       = 10,
  parameter int OUT_W       = 13,
  parameter int KP          = 40,
  parameter int KI_SHIFT    = 3,
  parameter int INT_LIM     = 2047,
  parameter int PITCH_SHIFT = 1,
  parameter int OFFSET      = 15,
  parameter int TICK_DIV    = 50000,
  parameter int RAMP_STEP   = 64,
  parameter int TILT_LIM    = 256,
  parameter int TILT_HYST   = 32,
  parameter int FAULT_HOLD  = 20,
  parameter int CAD_TIMEOUT = 40
) (
  input logic                    clk,
  input logic                    rst_n,
  pi_assist_controller_if.slave  bus
);

  // 64 bits holds err*KP for any 32-bit gain plus all other terms without overflow
  localparam int SUM_W   = 64;
  localparam int OUT_MAX = (1 << OUT_W) - 1;
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CAD_W   = $clog2(CAD_TIMEOUT + 1);
  localparam int HOLD_W  = $clog2(FAULT_HOLD + 1);
  localparam int INT_W   = $clog2(INT_LIM + 1) + 1;

  localparam logic signed [ANG_W:0] TILT_LIM_S  = (ANG_W+1)'(TILT_LIM);
  localparam logic signed [ANG_W:0] REARM_LIM_S = (ANG_W+1)'(TILT_LIM - TILT_HYST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSIST = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick;
  logic                    cad_s1, cad_s2, cad_s3;
  logic                    cad_rise;
  logic [CAD_W-1:0]        cad_timer;
  logic                    cad_active;
  logic signed [ANG_W:0]   roll_ext, roll_mag;
  logic                    tilt_over, rearm_ok;
  logic signed [HR_W:0]    err;
  logic signed [SUM_W-1:0] err_w, integ_w, pitch_w;
  logic signed [SUM_W-1:0] p_term, i_term, ff_term, sum, integ_acc;
  logic [OUT_W-1:0]        target, ramp_val;
  logic [OUT_W:0]          out_plus;
  logic signed [INT_W-1:0] integ, integ_next, integ_sat;
  logic                    windup_block;
  logic [HOLD_W-1:0]       hold_cnt, hold_next;
  logic [OUT_W-1:0]        out_q, out_next;
  logic                    strobe_q;

  // Control-rate tick
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Cadence synchroniser, rising-edge detect and activity timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cad_s1    <= 1'b0;
      cad_s2    <= 1'b0;
      cad_s3    <= 1'b0;
      cad_timer <= CAD_W'(CAD_TIMEOUT);
    end else begin
      cad_s1 <= bus.cadence;
      cad_s2 <= cad_s1;
      cad_s3 <= cad_s2;
      if (cad_rise)
        cad_timer <= '0;
      else if (tick && (cad_timer != CAD_W'(CAD_TIMEOUT)))
        cad_timer <= cad_timer + 1'b1;
    end
  end

  assign cad_rise   = cad_s2 & ~cad_s3;
  assign cad_active = (cad_timer < CAD_W'(CAD_TIMEOUT));

  // One extra bit so the most negative roll has a representable magnitude
  assign roll_ext  = {bus.resolved_roll[ANG_W-1], bus.resolved_roll};
  assign roll_mag  = roll_ext[ANG_W] ? -roll_ext : roll_ext;
  assign tilt_over = (roll_mag > TILT_LIM_S);
  assign rearm_ok  = (roll_mag <= REARM_LIM_S);

  assign err     = $signed({1'b0, bus.heart_rate}) - $signed({1'b0, bus.heart_rate_set_point});
  assign err_w   = {{(SUM_W-HR_W-1){err[HR_W]}}, err};
  assign integ_w = {{(SUM_W-INT_W){integ[INT_W-1]}}, integ};
  assign pitch_w = {{(SUM_W-ANG_W){bus.resolved_pitch[ANG_W-1]}}, bus.resolved_pitch};

  assign p_term  = err_w * $signed(SUM_W'(KP));
  assign i_term  = integ_w >>> KI_SHIFT;
  assign ff_term = bus.resolved_pitch[ANG_W-1] ? '0 : (pitch_w >>> PITCH_SHIFT);
  assign sum     = p_term + i_term + ff_term - $signed(SUM_W'(OFFSET));

  always_comb begin
    if (sum[SUM_W-1])
      target = '0;
    else if (sum > $signed(SUM_W'(OUT_MAX)))
      target = OUT_W'(OUT_MAX);
    else
      target = OUT_W'(sum);
  end

  // Upward moves are slew limited, downward moves apply at once
  assign out_plus = {1'b0, out_q} + (OUT_W+1)'(RAMP_STEP);

  always_comb begin
    ramp_val = target;
    if ((target > out_q) && (out_plus <= {1'b0, target}))
      ramp_val = OUT_W'(out_plus);
  end

  assign integ_acc = integ_w + err_w;

  always_comb begin
    if (integ_acc > $signed(SUM_W'(INT_LIM)))
      integ_sat = INT_W'(INT_LIM);
    else if (integ_acc < -$signed(SUM_W'(INT_LIM)))
      integ_sat = INT_W'(-INT_LIM);
    else
      integ_sat = INT_W'(integ_acc);
  end

  assign windup_block = ((out_q == OUT_W'(OUT_MAX)) && !err[HR_W] && (err != '0)) ||
                        ((out_q == '0) && err[HR_W]);

  always_comb begin
    state_next = state;
    out_next   = out_q;
    integ_next = integ;
    hold_next  = hold_cnt;
    case (state)
      S_IDLE: begin
        out_next   = '0;
        integ_next = '0;
        hold_next  = '0;
        if (tick && cad_active && !bus.brake && !tilt_over)
          state_next = S_ASSIST;
      end
      S_ASSIST: begin
        if (tilt_over) begin
          state_next = S_FAULT;
          out_next   = '0;
          integ_next = '0;
          hold_next  = '0;
        end else if (tick && !cad_active) begin
          state_next = S_IDLE;
          out_next   = '0;
          integ_next = '0;
        end else if (bus.brake) begin
          out_next = '0;
        end else if (tick) begin
          out_next = ramp_val;
          if (!windup_block)
            integ_next = integ_sat;
        end
      end
      S_FAULT: begin
        out_next   = '0;
        integ_next = '0;
        if (tick) begin
          if (!rearm_ok)
            hold_next = '0;
          else if (hold_cnt == HOLD_W'(FAULT_HOLD - 1)) begin
            state_next = S_IDLE;
            hold_next  = '0;
          end else
            hold_next = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        out_next   = '0;
        integ_next = '0;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_q    <= '0;
      integ    <= '0;
      hold_cnt <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_next;
      out_q    <= out_next;
      integ    <= integ_next;
      hold_cnt <= hold_next;
      strobe_q <= tick;
    end
  end

  assign bus.assistance_requirement = out_q;
  assign bus.assist_state           = state;
  assign bus.fault                  = (state == S_FAULT);
  assign bus.update_strobe          = strobe_q;

endmodule
